// File: rtl/ext_arb_pkg.sv
// Shared constants and types for the two-requester extension arbiter.
package ext_arb_pkg;

  localparam logic [1:0] EXT_S16 = 2'b00;
  localparam logic [1:0] EXT_Z16 = 2'b01;
  localparam logic [1:0] EXT_S8  = 2'b10;
  localparam logic [1:0] EXT_Z8  = 2'b11;

  localparam logic REQ_DEC = 1'b0;
  localparam logic REQ_LD  = 1'b1;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } ext_state_e;

endpackage

// File: rtl/ext_mode_unit.sv
// Combinational 16->32-bit sign/zero extender for halfword and byte operands.
module ext_mode_unit
  import ext_arb_pkg::*;
(
  input  logic [15:0] data_i,
  input  logic [1:0]  mode_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = 32'h0;
    unique case (mode_i)
      EXT_S16: result_o = {{16{data_i[15]}}, data_i};
      EXT_Z16: result_o = {16'h0, data_i};
      EXT_S8:  result_o = {{24{data_i[7]}}, data_i[7:0]};
      EXT_Z8:  result_o = {24'h0, data_i[7:0]};
      default: result_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/ext_unit_arbiter.sv
// Round-robin arbiter sharing one extension datapath between decode and load units.
// Optional counters enabled by defining EXT_ARB_STATS_EN.
module ext_unit_arbiter
  import ext_arb_pkg::*;
#(
  parameter int unsigned ID_W       = 1,
  parameter logic        RESET_LAST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in0_valid,
  output logic            in0_ready,
  input  logic [15:0]     in0_data,
  input  logic [1:0]      in0_mode,
  input  logic            in1_valid,
  output logic            in1_ready,
  input  logic [15:0]     in1_data,
  input  logic [1:0]      in1_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic [ID_W-1:0] out_id
`ifdef EXT_ARB_STATS_EN
  ,
  output logic [15:0]     grant0_cnt,
  output logic [15:0]     grant1_cnt,
  output logic [15:0]     stall_cnt
`endif
);

  ext_state_e      state_q, state_d;
  logic            last_q, last_d;
  logic [31:0]     data_q, data_d;
  logic [ID_W-1:0] id_q, id_d;

  logic        gnt0, gnt1, can_load;
  logic        acc0, acc1, acc;
  logic [15:0] sel_data;
  logic [1:0]  sel_mode;
  logic [31:0] ext_res;

  // Grant is independent of out_ready so a waiting requester keeps its grant.
  always_comb begin
    gnt0 = in0_valid && (!in1_valid || (last_q == REQ_LD));
    gnt1 = in1_valid && (!in0_valid || (last_q == REQ_DEC));
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign can_load  = !out_valid || out_ready;

  // Gating with rst_n keeps any handshake from completing in a reset cycle.
  assign in0_ready = rst_n && gnt0 && can_load;
  assign in1_ready = rst_n && gnt1 && can_load;
  assign acc0      = in0_valid && in0_ready;
  assign acc1      = in1_valid && in1_ready;
  assign acc       = acc0 || acc1;

  assign sel_data = acc1 ? in1_data : in0_data;
  assign sel_mode = acc1 ? in1_mode : in0_mode;

  ext_mode_unit u_ext (
    .data_i   (sel_data),
    .mode_i   (sel_mode),
    .result_o (ext_res)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    data_d  = data_q;
    id_d    = id_q;
    unique case (state_q)
      StEmpty: if (acc) state_d = StFull;
      StFull:  if (out_ready && !acc) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
    if (acc) begin
      data_d = ext_res;
      id_d   = acc1 ? ID_W'(REQ_LD) : ID_W'(REQ_DEC);
      last_d = acc1 ? REQ_LD : REQ_DEC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      last_q  <= RESET_LAST;
      data_q  <= 32'h0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

`ifdef EXT_ARB_STATS_EN
  logic [15:0] g0_q, g1_q, st_q;

  assign grant0_cnt = g0_q;
  assign grant1_cnt = g1_q;
  assign stall_cnt  = st_q;

  // Counters wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g0_q <= 16'h0;
      g1_q <= 16'h0;
      st_q <= 16'h0;
    end else begin
      if (acc0) g0_q <= g0_q + 16'h1;
      if (acc1) g1_q <= g1_q + 16'h1;
      if (out_valid && !out_ready) st_q <= st_q + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_ext_unit_arbiter.sv
// Directed vector bench for ext_unit_arbiter; stats checked when EXT_ARB_STATS_EN is defined.
module tb_ext_unit_arbiter;

  logic        clk;
  logic        rst_n;
  logic        in0_valid, in0_ready, in1_valid, in1_ready;
  logic [15:0] in0_data, in1_data;
  logic [1:0]  in0_mode, in1_mode;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [0:0]  out_id;
`ifdef EXT_ARB_STATS_EN
  logic [15:0] grant0_cnt, grant1_cnt, stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ext_unit_arbiter #(
    .ID_W       (1),
    .RESET_LAST (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in0_mode  (in0_mode),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .in1_mode  (in1_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
`ifdef EXT_ARB_STATS_EN
    ,
    .grant0_cnt (grant0_cnt),
    .grant1_cnt (grant1_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        v0;
    logic [15:0] d0;
    logic [1:0]  m0;
    logic        v1;
    logic [15:0] d1;
    logic [1:0]  m1;
    logic        ordy;
    logic        er0;   // expected in0_ready before the edge
    logic        er1;   // expected in1_ready before the edge
    logic        eov;   // expected out_valid after the edge
    logic        cd;    // compare out_data / out_id after the edge
    logic [31:0] ed;
    logic        eid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic v0, logic [15:0] d0, logic [1:0] m0,
                              logic v1, logic [15:0] d1, logic [1:0] m1, logic ordy,
                              logic er0, logic er1, logic eov, logic cd,
                              logic [31:0] ed, logic eid);
    vec_t v;
    v = '{rst: rst, v0: v0, d0: d0, m0: m0, v1: v1, d1: d1, m1: m1, ordy: ordy,
          er0: er0, er1: er1, eov: eov, cd: cd, ed: ed, eid: eid};
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v0, input logic [15:0] d0,
                       input logic [1:0] m0, input logic v1, input logic [15:0] d1,
                       input logic [1:0] m1, input logic ordy);
    rst_n     = rst;
    in0_valid = v0;
    in0_data  = d0;
    in0_mode  = m0;
    in1_valid = v1;
    in1_data  = d1;
    in1_mode  = m1;
    out_ready = ordy;
  endtask

  initial begin
    // reset with in0 pending
    vecs.push_back(mk(0, 1, 16'h80F0, 2'b00, 0, 16'h0, 2'b00, 1, 0, 0, 0, 1, 32'h0, 0));
    vecs.push_back(mk(0, 1, 16'h80F0, 2'b00, 0, 16'h0, 2'b00, 1, 0, 0, 0, 1, 32'h0, 0));
    // four modes on in0, back to back
    vecs.push_back(mk(1, 1, 16'h80F0, 2'b00, 0, 16'h0, 2'b00, 1, 1, 0, 1, 1, 32'hFFFF80F0, 0));
    vecs.push_back(mk(1, 1, 16'h80F0, 2'b01, 0, 16'h0, 2'b00, 1, 1, 0, 1, 1, 32'h000080F0, 0));
    vecs.push_back(mk(1, 1, 16'h80F0, 2'b10, 0, 16'h0, 2'b00, 1, 1, 0, 1, 1, 32'hFFFFFFF0, 0));
    vecs.push_back(mk(1, 1, 16'h80F0, 2'b11, 0, 16'h0, 2'b00, 1, 1, 0, 1, 1, 32'h000000F0, 0));
    // lone in1 request, then drain to empty
    vecs.push_back(mk(1, 0, 16'h0, 2'b00, 1, 16'h00FF, 2'b00, 1, 0, 1, 1, 1, 32'h000000FF, 1));
    vecs.push_back(mk(1, 0, 16'h0, 2'b00, 0, 16'h0, 2'b00, 1, 0, 0, 0, 0, 32'h0, 0));
    // contention: strict alternation starting with in0, no bubbles
    for (int i = 0; i < 6; i++) begin
      vecs.push_back(mk(1, 1, 16'h1234, 2'b01, 1, 16'hABCD, 2'b00, 1,
                        (i % 2 == 0), (i % 2 == 1), 1, 1,
                        (i % 2 == 0) ? 32'h00001234 : 32'hFFFFABCD, (i % 2 == 1)));
    end
    // backpressure: result held, both readys low
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(mk(1, 1, 16'h1234, 2'b01, 1, 16'hABCD, 2'b00, 0, 0, 0, 1, 1,
                        32'hFFFFABCD, 1));
    end
    // release: in0 loads in the same cycle out_ready rises
    vecs.push_back(mk(1, 1, 16'h1234, 2'b01, 1, 16'hABCD, 2'b00, 1, 1, 0, 1, 1,
                      32'h00001234, 0));
    // drain + accept from in1, out_valid stays high
    vecs.push_back(mk(1, 0, 16'h0, 2'b00, 1, 16'h007F, 2'b10, 1, 0, 1, 1, 1, 32'h0000007F, 1));
    vecs.push_back(mk(1, 0, 16'h0, 2'b00, 0, 16'h0, 2'b00, 1, 0, 0, 0, 0, 32'h0, 0));
    // reset mid-operation discards the held result and restores the pointer
    vecs.push_back(mk(1, 0, 16'h0, 2'b00, 1, 16'h8001, 2'b01, 1, 0, 1, 1, 1, 32'h00008001, 1));
    vecs.push_back(mk(0, 1, 16'h80F0, 2'b01, 1, 16'h0001, 2'b00, 0, 0, 0, 0, 1, 32'h0, 0));
    vecs.push_back(mk(1, 1, 16'h80F0, 2'b01, 1, 16'h0001, 2'b00, 1, 1, 0, 1, 1, 32'h000080F0, 0));

    drive(0, 0, 16'h0, 2'b00, 0, 16'h0, 2'b00, 0);
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].v0, vecs[i].d0, vecs[i].m0,
            vecs[i].v1, vecs[i].d1, vecs[i].m1, vecs[i].ordy);
      #1;
      check("in0_ready", i, {31'h0, in0_ready}, {31'h0, vecs[i].er0});
      check("in1_ready", i, {31'h0, in1_ready}, {31'h0, vecs[i].er1});
      @(posedge clk);
      #1;
      check("out_valid", i, {31'h0, out_valid}, {31'h0, vecs[i].eov});
      if (vecs[i].cd) begin
        check("out_data", i, out_data, vecs[i].ed);
        check("out_id", i, {31'h0, out_id}, {31'h0, vecs[i].eid});
      end
    end

`ifdef EXT_ARB_STATS_EN
    // contention then two stall cycles from a fresh reset
    @(negedge clk);
    drive(0, 0, 16'h0, 2'b00, 0, 16'h0, 2'b00, 1);
    @(negedge clk);
    drive(1, 1, 16'h1234, 2'b01, 1, 16'hABCD, 2'b00, 1);
    repeat (6) @(negedge clk);
    drive(1, 0, 16'h0, 2'b00, 0, 16'h0, 2'b00, 0);
    repeat (2) @(negedge clk);
    check("grant0_cnt", 0, {16'h0, grant0_cnt}, 32'd3);
    check("grant1_cnt", 0, {16'h0, grant1_cnt}, 32'd3);
    check("stall_cnt", 0, {16'h0, stall_cnt}, 32'd2);
    check("stall_out_id", 0, {31'h0, out_id}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
